dmem_access_seq: RTL

- Sequences every MEM-stage load/store onto a word-wide synchronous data memory.
- Splits accesses that cross a word boundary into two word accesses.
- Assembles load bytes and sign/zero-extends them; builds byte-enable masks for stores.
- Sits between the MEM stage and the data memory. The pipeline holds MEM while req_ready is low.

---
 rtl/dmem_access_seq_pkg.sv | 26 ++
 rtl/dmem_access_seq_if.sv | 43 ++++
 rtl/dmem_access_seq_lane_align.sv | 44 ++++
 rtl/dmem_access_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_seq_pkg.sv
// Shared definitions for the data-memory access sequencer: access size codes,
// FSM state encoding and the word-crossing test.
package dmem_access_seq_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RDA,
        ST_RDB,
        ST_CAPA,
        ST_CAPB,
        ST_WRA,
        ST_WRB,
        ST_RESP,
        ST_ERR
    } state_t;

    // True when the access touches bytes in two consecutive words.
    function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/dmem_access_seq_if.sv
// Bundles for the MEM-stage request/response side and the word-wide memory side.
interface dmem_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface dmem_mem_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_access_seq_lane_align.sv
// Byte-lane alignment between a right-aligned CPU datum and a two-word window:
// load shift/extend and store mask/data shift. Purely combinational.
module dmem_lane_align
    import dmem_access_seq_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_data,
    input  logic [31:0] st_data,
    output logic [7:0]  st_mask,
    output logic [63:0] st_lanes
);

    logic [63:0] ld_cat;
    logic [31:0] ld_word;
    logic        ext_b;
    logic        ext_h;

    always_comb begin
        ld_cat  = {ld_hi, ld_lo};
        ld_word = 32'(ld_cat >> {off, 3'b000});
        ext_b   = ~is_unsigned & ld_word[7];
        ext_h   = ~is_unsigned & ld_word[15];

        case (size)
            SZ_B:    ld_data = {{24{ext_b}}, ld_word[7:0]};
            SZ_H:    ld_data = {{16{ext_h}}, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        case (size)
            SZ_B:    st_mask = 8'h01 << off;
            SZ_H:    st_mask = 8'h03 << off;
            default: st_mask = 8'h0F << off;
        endcase
        st_lanes = {32'b0, st_data} << {off, 3'b000};
    end

endmodule

// File: rtl/dmem_access_seq.sv
// MEM-stage load/store sequencer for a word-wide synchronous data memory; splits
// word-crossing accesses into two word accesses.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request
// RDA     | read strobe to word A
// RDB     | capture word A (lo); read strobe to word B
// CAPA    | capture word A; assemble load result
// CAPB    | capture word B (hi); assemble load result
// WRA     | write lanes of word A
// WRB     | write lanes of word B
// RESP    | one-cycle completion pulse
// ERR     | one-cycle completion pulse with rsp_err
module dmem_access_seq
    import dmem_access_seq_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_req_if.slave  req,
    dmem_mem_if.master mem
);

    state_t state_q, state_d;

    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              mem_re_q, mem_re_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic              cur_idle;
    logic [ADDR_W+1:0] cur_addr;
    logic [1:0]        cur_size;
    logic              cur_uns;
    logic              cur_we;
    logic [31:0]       cur_wdata;
    logic [1:0]        cur_off;
    logic [ADDR_W-1:0] w_a;
    logic [ADDR_W-1:0] w_b;
    logic              cur_split;
    logic              cur_bad;

    logic [31:0]       ld_lo;
    logic [31:0]       ld_hi;
    logic [31:0]       ld_data;
    logic [7:0]        st_mask;
    logic [63:0]       st_lanes;

    assign req.req_ready = rst_n && (state_q == ST_IDLE);
    assign accept        = req.req_valid && req.req_ready;

    // In IDLE the outputs for the first access cycle are computed straight from
    // the request, since the latched copy only appears one edge later.
    always_comb begin
        cur_idle  = (state_q == ST_IDLE);
        cur_addr  = cur_idle ? req.req_addr[ADDR_W+1:0] : addr_q;
        cur_size  = cur_idle ? req.req_size             : size_q;
        cur_uns   = cur_idle ? req.req_unsigned         : uns_q;
        cur_we    = cur_idle ? req.req_we               : we_q;
        cur_wdata = cur_idle ? req.req_wdata            : wdata_q;
        cur_off   = cur_addr[1:0];
        w_a       = cur_addr[ADDR_W+1:2];
        w_b       = w_a + ADDR_W'(1);
        cur_split = is_split(cur_size, cur_off);
        cur_bad   = (cur_size == 2'd3) || (cur_split && !MISALIGN_EN);
    end

    always_comb begin
        ld_lo = (state_q == ST_CAPB) ? lo_q : mem.mem_rdata;
        ld_hi = (state_q == ST_CAPB) ? mem.mem_rdata : 32'b0;
    end

    dmem_lane_align u_align (
        .off         (cur_off),
        .size        (cur_size),
        .is_unsigned (cur_uns),
        .ld_lo       (ld_lo),
        .ld_hi       (ld_hi),
        .ld_data     (ld_data),
        .st_data     (cur_wdata),
        .st_mask     (st_mask),
        .st_lanes    (st_lanes)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = cur_addr;
                    size_d  = cur_size;
                    uns_d   = cur_uns;
                    we_d    = cur_we;
                    wdata_d = cur_wdata;
                    if (cur_bad)     state_d = ST_ERR;
                    else if (cur_we) state_d = ST_WRA;
                    else             state_d = ST_RDA;
                end
            end
            ST_RDA:  state_d = cur_split ? ST_RDB : ST_CAPA;
            ST_RDB: begin
                lo_d    = mem.mem_rdata;
                state_d = ST_CAPB;
            end
            ST_CAPA, ST_CAPB: state_d = ST_RESP;
            ST_WRA:  state_d = cur_split ? ST_WRB : ST_RESP;
            ST_WRB:  state_d = ST_RESP;
            ST_RESP, ST_ERR: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        mem_re_d    = 1'b0;
        mem_we_d    = 4'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 32'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'b0;

        case (state_d)
            ST_RDA: begin
                mem_re_d   = 1'b1;
                mem_addr_d = w_a;
            end
            ST_RDB: begin
                mem_re_d   = 1'b1;
                mem_addr_d = w_b;
            end
            ST_WRA: begin
                mem_addr_d  = w_a;
                mem_we_d    = st_mask[3:0];
                mem_wdata_d = st_lanes[31:0];
            end
            ST_WRB: begin
                mem_addr_d  = w_b;
                mem_we_d    = st_mask[7:4];
                mem_wdata_d = st_lanes[63:32];
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if ((state_q == ST_CAPA) || (state_q == ST_CAPB)) rsp_rdata_d = ld_data;
            end
            ST_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= 2'b0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= 32'b0;
            lo_q        <= 32'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 4'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_err   = rsp_err_q;
    assign req.rsp_rdata = rsp_rdata_q;
    assign mem.mem_re    = mem_re_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
